// File: rtl/param_queue_lvl.sv
// Parametrised synchronous FIFO with occupancy count, almost-full/almost-empty thresholds and sticky
// overflow/underflow flags. Define QUEUE_WATERMARK_EN to add the peak_count high-water-mark output.
module param_queue_lvl #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             enqueue,
    input  logic             dequeue,
    input  logic             clear_err,
    output logic [WIDTH-1:0] data_out,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             overflow,
    output logic             underflow
`ifdef QUEUE_WATERMARK_EN
    ,
    output logic [CW-1:0]    peak_count
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C     = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C     = CW'(AE_THRESH);

    generate
        if (DEPTH < 2 || AF_THRESH < 1 || AF_THRESH > DEPTH ||
            AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_param_err
            $error("param_queue_lvl: illegal DEPTH/AF_THRESH/AE_THRESH combination");
        end
    endgenerate

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             full_q, empty_q, af_q, ae_q;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             deq_ok, enq_ok;

    always_comb begin
        deq_ok = dequeue & ~empty_q;
        // A dequeue accepted this cycle frees a slot, so a full queue can still take a write.
        enq_ok = enqueue & (~full_q | deq_ok);

        count_d = count_q;
        case ({enq_ok, deq_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        wr_ptr_d = wr_ptr_q;
        if (enq_ok) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
        end

        rd_ptr_d   = rd_ptr_q;
        data_out_d = data_out_q;
        if (deq_ok) begin
            rd_ptr_d   = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
            data_out_d = mem[rd_ptr_q];
        end

        overflow_d  = (enqueue & ~enq_ok) | (overflow_q & ~clear_err);
        underflow_d = (dequeue & ~deq_ok) | (underflow_q & ~clear_err);
    end

    // Storage has no reset; pointers and count make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (enq_ok) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            af_q        <= 1'b0;
            ae_q        <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            full_q      <= (count_d == DEPTH_C);
            empty_q     <= (count_d == '0);
            af_q        <= (count_d >= AF_C);
            ae_q        <= (count_d <= AE_C);
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

`ifdef QUEUE_WATERMARK_EN
    logic [CW-1:0] peak_q, peak_d;

    always_comb begin
        if (clear_err) begin
            peak_d = count_d;
        end else begin
            peak_d = (count_d > peak_q) ? count_d : peak_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak_count = peak_q;
`endif

    assign data_out     = data_out_q;
    assign count        = count_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_param_queue_lvl.sv
// Directed-vector bench for param_queue_lvl: a DEPTH=16 instance driven from a vector table and a
// DEPTH=5 instance for pointer wrap-around.
module tb_param_queue_lvl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic [7:0] din_a = '0;
    logic       enq_a = 1'b0, deq_a = 1'b0, clr_a = 1'b0;
    logic [7:0] dout_a;
    logic [4:0] cnt_a;
    logic       full_a, empty_a, af_a, ae_a, ovf_a, unf_a;
`ifdef QUEUE_WATERMARK_EN
    logic [4:0] peak_a;
`endif

    logic [7:0] din_b = '0;
    logic       enq_b = 1'b0, deq_b = 1'b0, clr_b = 1'b0;
    logic [7:0] dout_b;
    logic [2:0] cnt_b;
    logic       full_b, empty_b, af_b, ae_b, ovf_b, unf_b;

    param_queue_lvl #(.WIDTH(8), .DEPTH(16)) u_dut_a (
        .clk(clk), .rst(rst), .data_in(din_a), .enqueue(enq_a), .dequeue(deq_a),
        .clear_err(clr_a), .data_out(dout_a), .count(cnt_a), .full(full_a), .empty(empty_a),
        .almost_full(af_a), .almost_empty(ae_a), .overflow(ovf_a), .underflow(unf_a)
`ifdef QUEUE_WATERMARK_EN
        , .peak_count(peak_a)
`endif
    );

    param_queue_lvl #(.WIDTH(8), .DEPTH(5)) u_dut_b (
        .clk(clk), .rst(rst), .data_in(din_b), .enqueue(enq_b), .dequeue(deq_b),
        .clear_err(clr_b), .data_out(dout_b), .count(cnt_b), .full(full_b), .empty(empty_b),
        .almost_full(af_b), .almost_empty(ae_b), .overflow(ovf_b), .underflow(unf_b)
`ifdef QUEUE_WATERMARK_EN
        , .peak_count()
`endif
    );

    typedef struct {
        logic       rst, enq, deq, clr;
        logic [7:0] din;
        logic [4:0] cnt;
        logic [7:0] dout;
        logic [5:0] flg;   // {full, empty, almost_full, almost_empty, overflow, underflow}
    } vec_t;

    vec_t tbl[$];
    int   nvec = 0;
    int   nerr = 0;

    // Expected flags for the DEPTH=16 instance: AF_THRESH=14, AE_THRESH=2.
    task automatic add(input logic r, e, d, c, input logic [7:0] di, input int n,
                       input logic [7:0] dout, input logic ovf, unf);
        vec_t v;
        v.rst = r; v.enq = e; v.deq = d; v.clr = c; v.din = di;
        v.cnt = 5'(n);
        v.dout = dout;
        v.flg = {n == 16, n == 0, n >= 14, n <= 2, ovf, unf};
        tbl.push_back(v);
    endtask

    task automatic apply_a(input int idx);
        vec_t v;
        logic [5:0] got;
        v = tbl[idx];
        rst = v.rst; enq_a = v.enq; deq_a = v.deq; clr_a = v.clr; din_a = v.din;
        @(posedge clk);
        #1;
        got = {full_a, empty_a, af_a, ae_a, ovf_a, unf_a};
        nvec++;
        if (cnt_a !== v.cnt || dout_a !== v.dout || got !== v.flg) begin
            nerr++;
            $display("FAIL vec%0d: count=%0d dout=%h flags=%b, expected count=%0d dout=%h flags=%b",
                     idx, cnt_a, dout_a, got, v.cnt, v.dout, v.flg);
        end
    endtask

    task automatic step_b(input string name, input logic e, d, c, input logic [7:0] di,
                          input int n, input logic [7:0] dout, input logic ovf, unf);
        enq_b = e; deq_b = d; clr_b = c; din_b = di;
        @(posedge clk);
        #1;
        nvec++;
        if (cnt_b !== 3'(n) || dout_b !== dout || ovf_b !== ovf || unf_b !== unf) begin
            nerr++;
            $display("FAIL %s: count=%0d dout=%h ovf=%b unf=%b, expected count=%0d dout=%h ovf=%b unf=%b",
                     name, cnt_b, dout_b, ovf_b, unf_b, n, dout, ovf, unf);
        end
    endtask

    initial begin
        // Reset, a short stream, then reset asserted mid-stream with an enqueue pending.
        add(1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0);
        add(0, 1, 0, 0, 8'h33, 1, 8'h00, 0, 0);
        add(0, 1, 0, 0, 8'h44, 2, 8'h00, 0, 0);
        add(1, 1, 0, 0, 8'h99, 0, 8'h00, 0, 0);
        add(0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0);
        // Fill 0x00..0x0F, then a rejected 17th word.
        for (int i = 0; i < 16; i++) add(0, 1, 0, 0, 8'(i), i + 1, 8'h00, 0, 0);
        add(0, 1, 0, 0, 8'hAA, 16, 8'h00, 1, 0);
        // Drain in order; overflow stays sticky; extra dequeue sets underflow and holds data.
        for (int i = 0; i < 16; i++) add(0, 0, 1, 0, 8'h00, 15 - i, 8'(i), 1, 0);
        add(0, 0, 1, 0, 8'h00, 0, 8'h0F, 1, 1);
        add(0, 0, 0, 1, 8'h00, 0, 8'h0F, 0, 0);
        // Refill with 0x10..0x1F, then simultaneous enqueue+dequeue at full.
        for (int i = 0; i < 16; i++) add(0, 1, 0, 0, 8'(16 + i), i + 1, 8'h0F, 0, 0);
        add(0, 1, 1, 0, 8'h55, 16, 8'h10, 0, 0);
        for (int i = 0; i < 15; i++) add(0, 0, 1, 0, 8'h00, 15 - i, 8'(17 + i), 0, 0);
        add(0, 0, 1, 0, 8'h00, 0, 8'h55, 0, 0);
        // Empty with enqueue+dequeue: write taken, read rejected.
        add(0, 1, 1, 0, 8'h77, 1, 8'h55, 0, 1);
        add(0, 0, 1, 0, 8'h00, 0, 8'h77, 0, 1);
        // Set wins over clear in the same cycle; then a plain clear.
        add(0, 0, 1, 1, 8'h00, 0, 8'h77, 0, 1);
        add(0, 0, 0, 1, 8'h00, 0, 8'h77, 0, 0);

        for (int i = 0; i < tbl.size(); i++) apply_a(i);
        enq_a = 0; deq_a = 0; clr_a = 0;

        // DEPTH=5 instance: 12 words through a 5-entry ring, read pointer wraps twice.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) step_b("wrap_fill", 1, 0, 0, 8'(k), k, 8'h00, 0, 0);
        for (int k = 4; k <= 12; k++) step_b("wrap_both", 1, 1, 0, 8'(k), 3, 8'(k - 3), 0, 0);
        for (int k = 10; k <= 12; k++) step_b("wrap_drain", 0, 1, 0, 8'h00, 12 - k, 8'(k), 0, 0);
        step_b("wrap_clear", 0, 0, 1, 8'h00, 0, 8'h0C, 0, 0);
        for (int k = 1; k <= 5; k++) step_b("b_full", 1, 0, 0, 8'(k + 32), k, 8'h0C, 0, 0);
        step_b("b_ovf", 1, 0, 0, 8'hEE, 5, 8'h0C, 1, 0);
        nvec++;
        if (full_b !== 1'b1 || af_b !== 1'b1 || empty_b !== 1'b0 || ae_b !== 1'b0) begin
            nerr++;
            $display("FAIL b_flags: full=%b af=%b empty=%b ae=%b, expected 1 1 0 0",
                     full_b, af_b, empty_b, ae_b);
        end
        step_b("b_first_out", 0, 1, 0, 8'h00, 4, 8'h21, 1, 0);
        enq_b = 0; deq_b = 0; clr_b = 0;

`ifdef QUEUE_WATERMARK_EN
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        nvec++;
        if (peak_a !== 5'd0) begin
            nerr++;
            $display("FAIL peak_reset: peak=%0d, expected 0", peak_a);
        end
        for (int i = 0; i < 9; i++) begin
            enq_a = 1; din_a = 8'(i);
            @(posedge clk);
            #1;
        end
        enq_a = 0;
        for (int i = 0; i < 6; i++) begin
            deq_a = 1;
            @(posedge clk);
            #1;
        end
        deq_a = 0;
        nvec++;
        if (peak_a !== 5'd9 || cnt_a !== 5'd3) begin
            nerr++;
            $display("FAIL peak_hold: peak=%0d count=%0d, expected peak=9 count=3", peak_a, cnt_a);
        end
        clr_a = 1;
        @(posedge clk);
        #1;
        clr_a = 0;
        nvec++;
        if (peak_a !== 5'd3) begin
            nerr++;
            $display("FAIL peak_clear: peak=%0d, expected 3", peak_a);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
